hazard_controller: RTL

//  Pipeline sequencer for the 5-stage MIPS core: drives stall (enable-low) and

---
 rtl/hazard_controller_if.sv | 33 +++
 rtl/hazard_controller.sv | 148 ++++++++++++++
 2 files changed

// File: rtl/hazard_controller_if.sv
// hazard_controller_if
//   Groups the pipeline-status inputs and the stall/flush/forward controls
//   exchanged between the MIPS datapath and the hazard controller.
//   master : datapath side (drives pipeline status, receives controls)
//   slave  : controller side (receives pipeline status, drives controls)
interface hazard_controller_if;
  logic [4:0] rs_d, rt_d, rs_e, rt_e;
  logic [4:0] write_reg_e, write_reg_m, write_reg_w;
  logic       reg_write_e, reg_write_m, reg_write_w;
  logic       mem_to_reg_e, mem_to_reg_m;
  logic       branch_d, branch_taken_d, jump_d, muldiv_start_e;
  logic       stall_f, stall_d, stall_e;
  logic       flush_d, flush_e, flush_m;
  logic [1:0] forward_a_e, forward_b_e;
  logic       forward_a_d, forward_b_d;
  logic       muldiv_busy;

  modport master (
    output rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, branch_taken_d, jump_d, muldiv_start_e,
    input  stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           forward_a_e, forward_b_e, forward_a_d, forward_b_d, muldiv_busy
  );

  modport slave (
    input  rs_d, rt_d, rs_e, rt_e, write_reg_e, write_reg_m, write_reg_w,
           reg_write_e, reg_write_m, reg_write_w, mem_to_reg_e, mem_to_reg_m,
           branch_d, branch_taken_d, jump_d, muldiv_start_e,
    output stall_f, stall_d, stall_e, flush_d, flush_e, flush_m,
           forward_a_e, forward_b_e, forward_a_d, forward_b_d, muldiv_busy
  );
endinterface

// File: rtl/hazard_controller.sv
// hazard_controller
//   Pipeline sequencer for the 5-stage MIPS core: operand forwarding,
//   load-use / branch-compare stalls, taken-branch/jump redirect flush, and a
//   hold FSM covering the multi-cycle mult/div unit.
// Ports
//   clock        rising-edge clock
//   reset_n      asynchronous active-low reset; forces every control output to 0
//   hz           hazard_controller_if.slave: pipeline status in, controls out
//   stall_cycles (HAZARD_PERF_CNT_EN only) cycles with stall_f asserted
//   flush_count  (HAZARD_PERF_CNT_EN only) cycles with flush_d asserted
// Configuration macro: HAZARD_PERF_CNT_EN adds the two performance counters.
//
// state   | meaning
// RUN     | normal flow; mult/div entering EX starts the hold (1st stall cycle)
// MD_BUSY | mult/div occupying EX; hold while cnt!=0, release when cnt==0
module hazard_controller #(
  parameter int MULDIV_LATENCY = 6
) (
  input  logic              clock,
  input  logic              reset_n,
  hazard_controller_if.slave hz
`ifdef HAZARD_PERF_CNT_EN
  ,
  output logic [31:0]       stall_cycles,
  output logic [31:0]       flush_count
`endif
);

  if (MULDIV_LATENCY < 2 || MULDIV_LATENCY > 32) begin : g_bad_latency
    $error("MULDIV_LATENCY must be in 2..32");
  end

  typedef enum logic {RUN = 1'b0, MD_BUSY = 1'b1} state_t;

  // First hold cycle happens in RUN, so the counter covers the remaining ones.
  localparam logic [4:0] CNT_LOAD = 5'(MULDIV_LATENCY - 2);

  state_t     state, state_next;
  logic [4:0] cnt, cnt_next;
  logic       md_hold;
  logic       lwstall, brstall;
  logic       dep_e_d, dep_m_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= RUN;
      cnt   <= 5'd0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next = state;
    cnt_next   = cnt;
    md_hold    = 1'b0;
    case (state)
      RUN: begin
        if (hz.muldiv_start_e) begin
          md_hold    = 1'b1;
          state_next = MD_BUSY;
          cnt_next   = CNT_LOAD;
        end
      end
      MD_BUSY: begin
        if (cnt != 5'd0) begin
          md_hold  = 1'b1;
          cnt_next = cnt - 5'd1;
        end else begin
          state_next = RUN;
        end
      end
      default: state_next = RUN;
    endcase
  end

  // Register-dependency terms between ID sources and EX/MEM destinations.
  assign dep_e_d = (hz.write_reg_e != 5'd0) &&
                   ((hz.write_reg_e == hz.rs_d) || (hz.write_reg_e == hz.rt_d));
  assign dep_m_d = (hz.write_reg_m != 5'd0) &&
                   ((hz.write_reg_m == hz.rs_d) || (hz.write_reg_m == hz.rt_d));

  assign lwstall = hz.mem_to_reg_e && dep_e_d;
  assign brstall = hz.branch_d && ((hz.reg_write_e && dep_e_d) ||
                                   (hz.mem_to_reg_m && dep_m_d));

  always_comb begin
    hz.stall_f     = 1'b0;
    hz.stall_d     = 1'b0;
    hz.stall_e     = 1'b0;
    hz.flush_d     = 1'b0;
    hz.flush_e     = 1'b0;
    hz.flush_m     = 1'b0;
    hz.forward_a_e = 2'b00;
    hz.forward_b_e = 2'b00;
    hz.forward_a_d = 1'b0;
    hz.forward_b_d = 1'b0;
    hz.muldiv_busy = 1'b0;

    if (reset_n) begin
      // MEM result is newer than WB, so it wins on a double match.
      if (hz.reg_write_m && hz.write_reg_m != 5'd0 && hz.write_reg_m == hz.rs_e)
        hz.forward_a_e = 2'b10;
      else if (hz.reg_write_w && hz.write_reg_w != 5'd0 && hz.write_reg_w == hz.rs_e)
        hz.forward_a_e = 2'b01;

      if (hz.reg_write_m && hz.write_reg_m != 5'd0 && hz.write_reg_m == hz.rt_e)
        hz.forward_b_e = 2'b10;
      else if (hz.reg_write_w && hz.write_reg_w != 5'd0 && hz.write_reg_w == hz.rt_e)
        hz.forward_b_e = 2'b01;

      hz.forward_a_d = hz.reg_write_m && hz.write_reg_m != 5'd0 &&
                       hz.write_reg_m == hz.rs_d;
      hz.forward_b_d = hz.reg_write_m && hz.write_reg_m != 5'd0 &&
                       hz.write_reg_m == hz.rt_d;

      if (md_hold) begin
        // Freeze front end and EX; bubble into MEM while mult/div runs.
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.stall_e = 1'b1;
        hz.flush_m = 1'b1;
      end else if (lwstall || brstall) begin
        hz.stall_f = 1'b1;
        hz.stall_d = 1'b1;
        hz.flush_e = 1'b1;
      end

      // A redirect is only meaningful when the ID instruction is advancing.
      hz.flush_d     = (hz.jump_d || hz.branch_taken_d) && !hz.stall_d;
      hz.muldiv_busy = (state == MD_BUSY);
    end
  end

`ifdef HAZARD_PERF_CNT_EN
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      stall_cycles <= 32'd0;
      flush_count  <= 32'd0;
    end else begin
      if (hz.stall_f) stall_cycles <= stall_cycles + 32'd1;
      if (hz.flush_d) flush_count  <= flush_count + 32'd1;
    end
  end
`endif

endmodule
